// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp encodings and the mul/div sequencer state and mode types.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;
    localparam logic [3:0] ALU_DIV = 4'd8;
    localparam logic [3:0] ALU_NA  = 4'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } md_state_e;

    typedef enum logic {
        ModeMul = 1'b0,
        ModeDiv = 1'b1
    } md_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  md_mode_e          mode_i,
    input  logic [XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]   sa_i,
    input  logic [XLEN-1:0]   sb_i,
    output logic [XLEN-1:0]   acc_o,
    output logic [XLEN-1:0]   sa_o,
    output logic [XLEN-1:0]   sb_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        // DIV: acc is the partial remainder, sa shifts dividend bits out and quotient bits in
        rem_sh = {acc_i, sa_i[XLEN-1]};
        diff   = rem_sh - {1'b0, sb_i};
        acc_o  = acc_i;
        sa_o   = sa_i;
        sb_o   = sb_i;
        if (mode_i == ModeDiv) begin
            if (diff[XLEN]) begin
                acc_o = rem_sh[XLEN-1:0];
                sa_o  = {sa_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = diff[XLEN-1:0];
                sa_o  = {sa_i[XLEN-2:0], 1'b1};
            end
        end else begin
            if (sb_i[0]) begin
                acc_o = acc_i + sa_i;
            end
            sa_o = sa_i << 1;
            sb_o = sb_i >> 1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV sequencer; stalls the core while iterating, one-cycle done strobe.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned CntW = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e       state_q, state_d;
    md_mode_e        mode_q, mode_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] sa_q, sa_d;
    logic [XLEN-1:0] sb_q, sb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;

    logic [XLEN-1:0] step_acc, step_sa, step_sb;
    logic            accept;
    logic            is_div;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .sa_i   (sa_q),
        .sb_i   (sb_q),
        .acc_o  (step_acc),
        .sa_o   (step_sa),
        .sb_o   (step_sb)
    );

    always_comb begin
        is_div   = (alu_op_i == ALU_DIV);
        accept   = (state_q == StIdle) & start_i & ((alu_op_i == ALU_MUL) | is_div) & ~flush_i;
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = CntW'(XLEN - 1);
                    acc_d   = '0;
                    state_d = StRun;
                    if (is_div) begin
                        mode_d = ModeDiv;
                        sa_d   = op_a_i[XLEN-1] ? -op_a_i : op_a_i;
                        sb_d   = op_b_i[XLEN-1] ? -op_b_i : op_b_i;
                        neg_d  = op_a_i[XLEN-1] ^ op_b_i[XLEN-1];
                        if (op_b_i == '0) begin
                            state_d  = StDone;
                            result_d = '1;
                        end
                    end else begin
                        mode_d = ModeMul;
                        sa_d   = op_a_i;
                        sb_d   = op_b_i;
                        neg_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step_acc;
                    sa_d  = step_sa;
                    sb_d  = step_sb;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d = StDone;
                        if (mode_q == ModeDiv) begin
                            result_d = neg_q ? -step_sa : step_sa;
                        end else begin
                            result_d = step_acc;
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            mode_q   <= ModeMul;
            cnt_q    <= '0;
            acc_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = accept | (state_q == StRun);
    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + light random bench for muldiv_sequencer with a result scoreboard.
module tb_muldiv_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = ALU_NA;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN (32)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .alu_op_i (alu_op),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .flush_i  (flush),
        .stall_o  (stall),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        start  = 1'b1;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        if (push) sb_q.push_back(exp);
        #1;
        check("stall_on_start", {31'b0, stall}, 32'd1);
        @(negedge clk);
        start  = 1'b0;
        alu_op = ALU_NA;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int          n;
        logic [31:0] exp;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
        last_res = exp;
        @(negedge clk);
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;

        #1;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(ALU_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_done("mul_7x6", 33);

        issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        wait_done("mul_ffff_x2", 33);

        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        wait_done("div_m7_2", 33);

        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done("div_ovf", 33);

        issue(ALU_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
        check("div0_busy_c1", {31'b0, busy}, 32'd1);
        wait_done("div0", 1);

        // Abort in RUN: no done, result kept, immediate reissue works.
        issue(ALU_MUL, 32'h1234, 32'h5678, 32'd0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            check("flush_no_early_done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        flush = 1'b1;
        check("flush_busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result_kept", result, last_res);
        issue(ALU_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
        wait_done("mul_3x5_after_flush", 33);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            issue(ALU_MUL, ra, rb, ra * rb, 1'b1);
            wait_done("rand_mul", 33);
            rb = 32'($urandom_range(2, 1000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            issue(ALU_DIV, ra, rb, 32'($signed(ra) / $signed(rb)), 1'b1);
            wait_done("rand_div", 33);
        end

        // Asynchronous reset mid-RUN.
        issue(ALU_MUL, 32'd9, 32'd9, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        start  = 1'b1;
        alu_op = ALU_ADD;
        op_a   = 32'd1;
        op_b   = 32'd2;
        #1;
        check("add_no_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start  = 1'b0;
        alu_op = ALU_NA;
        check("add_stays_idle", {31'b0, busy}, 32'd0);
        check("add_no_done", {31'b0, done}, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
